cbfp_shift_norm_pipe: RTL and testbench

//  Parametrised CBFP normalisation stage: rescales DATA_WIDTH complex lanes by a per-group

---
 rtl/cbfp_shift_norm_pipe_if.sv | 39 +++
 rtl/cbfp_shift_norm_pipe.sv | 166 ++++++++++++++++
 tb/tb_cbfp_shift_norm_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbfp_shift_norm_pipe_if.sv
// rtl/cbfp_shift_norm_pipe_if.sv - stream bundle for the CBFP normalisation stage
// Purpose: carries the input beat (lanes, group exponents) and the output beat
//          (scaled lanes, per-lane exponents) with their valid/ready handshakes.
// Signals:
//   in_valid/in_ready      input beat handshake
//   din_re/din_im          DATA_WIDTH x I_WIDTH signed input lanes
//   min_cnt                NUM_GRP x CNT_W per-group exponent
//   out_valid/out_ready    output beat handshake
//   dout_re/dout_im        DATA_WIDTH x O_WIDTH signed scaled lanes
//   min_cnt_out            DATA_WIDTH x CNT_W exponent applied to each lane
// Modports: master = beat producer / consumer side, slave = normalisation stage.
interface cbfp_shift_norm_pipe_if #(
  parameter int I_WIDTH    = 24,
  parameter int O_WIDTH    = 12,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_GRP    = 2,
  parameter int CNT_W      = 5
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]   din_re;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]   din_im;
  logic [NUM_GRP-1:0][CNT_W-1:0]        min_cnt;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   dout_re;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   dout_im;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]     min_cnt_out;

  modport master (
    output in_valid, din_re, din_im, min_cnt, out_ready,
    input  in_ready, out_valid, dout_re, dout_im, min_cnt_out
  );

  modport slave (
    input  in_valid, din_re, din_im, min_cnt, out_ready,
    output in_ready, out_valid, dout_re, dout_im, min_cnt_out
  );
endinterface

// File: rtl/cbfp_shift_norm_pipe.sv
// rtl/cbfp_shift_norm_pipe.sv - CBFP block-exponent normalisation, 2-stage elastic pipe
// Purpose: rescales every complex lane by 2^(min_cnt[g]-LENGTH) of its group g,
//          with optional round-half-up and saturation, and counts overflowing beats.
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   rnd_en           1: round half up on right shifts, 0: floor
//   sat_en           1: clamp to O_WIDTH range, 0: keep low O_WIDTH bits
//   clr_sat          synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt          beats with at least one out-of-range component, sticky at max
//   bus              stream bundle (slave side): input beat in, scaled beat out
module cbfp_shift_norm_pipe #(
  parameter int LENGTH     = 13,
  parameter int I_WIDTH    = 24,
  parameter int O_WIDTH    = 12,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_GRP    = 2,
  parameter int CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rnd_en,
  input  logic                   sat_en,
  input  logic                   clr_sat,
  output logic [15:0]            sat_cnt,
  cbfp_shift_norm_pipe_if.slave  bus
);

  localparam int LANES_PER_GRP = DATA_WIDTH / NUM_GRP;
  // Wide enough to hold the largest exact left shift (< 2^CNT_W) plus the
  // rounding carry, so no intermediate ever wraps.
  localparam int EXT_W = I_WIDTH + (1 << CNT_W) + 1;

  // Stage 1: captured beat, per-lane exponent and the modes it travels with.
  logic                                 s1_v;
  logic                                 s1_rnd;
  logic                                 s1_sat;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]   s1_re;
  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]   s1_im;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]     s1_cnt;

  // Stage 2: finished result.
  logic                                 s2_v;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   s2_re;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   s2_im;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]     s2_cnt;

  logic                                 s1_load;
  logic                                 s2_load;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]     lane_cnt;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   nrm_re;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0]   nrm_im;
  logic [DATA_WIDTH-1:0]                ovf_re;
  logic [DATA_WIDTH-1:0]                ovf_im;
  logic                                 beat_ovf;

  // Returns {overflow, y[O_WIDTH-1:0]} for one component.
  function automatic logic [O_WIDTH:0] norm(
    input logic [I_WIDTH-1:0] x,
    input logic [CNT_W-1:0]   c,
    input logic               rnd,
    input logic               sat
  );
    logic signed [EXT_W-1:0]   xe;
    logic signed [EXT_W-1:0]   half;
    logic signed [EXT_W-1:0]   y;
    logic [EXT_W-O_WIDTH:0]    top;
    logic [O_WIDTH-1:0]        res;
    logic                      ovf;
    int                        cv;
    int                        r;
    xe   = {{(EXT_W-I_WIDTH){x[I_WIDTH-1]}}, x};
    cv   = int'(c);
    r    = 0;
    half = '0;
    y    = xe;
    if (cv > LENGTH) begin
      y = xe <<< (cv - LENGTH);
    end else begin
      r = LENGTH - cv;
      if (rnd && r >= I_WIDTH) begin
        // Rounding a shift that discards every magnitude bit always lands on 0.
        y = '0;
      end else if (rnd && r > 0) begin
        half = {{(EXT_W-1){1'b0}}, 1'b1} << (r - 1);
        y    = (xe + half) >>> r;
      end else begin
        y = xe >>> r;
      end
    end
    // In range iff every bit from the output sign bit upward agrees.
    top = y[EXT_W-1:O_WIDTH-1];
    ovf = !((&top) || !(|top));
    if (ovf && sat)
      res = y[EXT_W-1] ? {1'b1, {(O_WIDTH-1){1'b0}}} : {1'b0, {(O_WIDTH-1){1'b1}}};
    else
      res = y[O_WIDTH-1:0];
    return {ovf, res};
  endfunction

  // Fan each group exponent out to its lanes.
  for (genvar l = 0; l < DATA_WIDTH; l++) begin : g_lane
    assign lane_cnt[l] = bus.min_cnt[l / LANES_PER_GRP];
    assign {ovf_re[l], nrm_re[l]} = norm(s1_re[l], s1_cnt[l], s1_rnd, s1_sat);
    assign {ovf_im[l], nrm_im[l]} = norm(s1_im[l], s1_cnt[l], s1_rnd, s1_sat);
  end

  assign beat_ovf = |(ovf_re | ovf_im);

  // Elastic handshake: S2 takes a beat when empty or draining; S1 accepts
  // whenever it is empty or hands its beat to S2 this cycle.
  assign s2_load      = s1_v & (~s2_v | bus.out_ready);
  assign s1_load      = bus.in_valid & bus.in_ready;
  assign bus.in_ready = ~s1_v | s2_load;

  assign bus.out_valid   = s2_v;
  assign bus.dout_re     = s2_re;
  assign bus.dout_im     = s2_im;
  assign bus.min_cnt_out = s2_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v   <= 1'b0;
      s1_rnd <= 1'b0;
      s1_sat <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_cnt <= '0;
    end else if (s1_load) begin
      s1_v   <= 1'b1;
      s1_rnd <= rnd_en;
      s1_sat <= sat_en;
      s1_re  <= bus.din_re;
      s1_im  <= bus.din_im;
      s1_cnt <= lane_cnt;
    end else if (s2_load) begin
      s1_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v   <= 1'b0;
      s2_re  <= '0;
      s2_im  <= '0;
      s2_cnt <= '0;
    end else if (s2_load) begin
      s2_v   <= 1'b1;
      s2_re  <= nrm_re;
      s2_im  <= nrm_im;
      s2_cnt <= s1_cnt;
    end else if (bus.out_ready) begin
      s2_v   <= 1'b0;
    end
  end

  // Overflow is counted whether or not the result was clamped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_cnt <= '0;
    else if (clr_sat)
      sat_cnt <= '0;
    else if (s2_load && beat_ovf && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_cbfp_shift_norm_pipe.sv
// tb/tb_cbfp_shift_norm_pipe.sv - self-checking bench for cbfp_shift_norm_pipe
module tb_cbfp_shift_norm_pipe;

  localparam int L    = 13;
  localparam int IW   = 24;
  localparam int OW   = 12;
  localparam int DW   = 16;
  localparam int CW   = 5;
  localparam int OMAX = (1 << (OW - 1)) - 1;
  localparam int OMIN = -(1 << (OW - 1));

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rnd_en = 1'b0;
  logic        sat_en = 1'b0;
  logic        clr_sat = 1'b0;
  logic [15:0] sat_cnt2;
  logic [15:0] sat_cnt4;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  cbfp_shift_norm_pipe_if #(.I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(DW), .NUM_GRP(2), .CNT_W(CW)) if2 ();
  cbfp_shift_norm_pipe_if #(.I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(DW), .NUM_GRP(4), .CNT_W(CW)) if4 ();

  cbfp_shift_norm_pipe #(.LENGTH(L), .I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(DW), .NUM_GRP(2), .CNT_W(CW)) dut2 (
    .clk(clk), .rstn(rstn), .rnd_en(rnd_en), .sat_en(sat_en), .clr_sat(clr_sat),
    .sat_cnt(sat_cnt2), .bus(if2)
  );

  cbfp_shift_norm_pipe #(.LENGTH(L), .I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(DW), .NUM_GRP(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rstn(rstn), .rnd_en(rnd_en), .sat_en(sat_en), .clr_sat(clr_sat),
    .sat_cnt(sat_cnt4), .bus(if4)
  );

  typedef struct {
    int re[DW];
    int im[DW];
    int cnt[DW];
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact scaling by 2^(c-L) with floor / round-half-up, then clamp or wrap.
  function automatic int model_scale(input int x, input int c, input bit rnd, input bit sat, output bit ovf);
    longint y;
    longint d;
    longint a;
    int     r;
    if (c > L) begin
      y = longint'(x) * (longint'(1) << (c - L));
    end else begin
      r = L - c;
      d = longint'(1) << r;
      if (r == 0) begin
        y = x;
      end else begin
        a = rnd ? longint'(x) + d / 2 : longint'(x);
        y = a / d;
        if ((a % d) != 0 && a < 0) y = y - 1;
      end
    end
    ovf = (y > OMAX) || (y < OMIN);
    if (!ovf) return int'(y);
    if (sat) return (y > 0) ? OMAX : OMIN;
    y = y & ((longint'(1) << OW) - 1);
    if (y > OMAX) y = y - (longint'(1) << OW);
    return int'(y);
  endfunction

  // Scoreboard for dut2: predict on accept, compare on every output transfer,
  // and insist the output stays frozen while stalled.
  bit                    held = 0;
  logic [DW-1:0][OW-1:0] held_re;
  logic [DW-1:0][OW-1:0] held_im;
  logic [DW-1:0][CW-1:0] held_cnt;
  int                    beat_no = 0;

  always @(negedge clk) begin
    beat_t b;
    beat_t nb;
    bit    o;
    bit    any_ovf;
    int    bad;
    if (!rstn) begin
      held = 0;
    end else begin
      if (if2.out_valid) begin
        if (held)
          chk("hold_stable", (if2.dout_re == held_re && if2.dout_im == held_im && if2.min_cnt_out == held_cnt) ? 1 : 0, 1);
        if (if2.out_ready) begin
          held = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            bad = -1;
            for (int l = 0; l < DW; l++)
              if (b.re[l] != int'($signed(if2.dout_re[l])) || b.im[l] != int'($signed(if2.dout_im[l])) ||
                  b.cnt[l] != int'(if2.min_cnt_out[l]))
                bad = l;
            checks++;
            if (bad >= 0) begin
              errors++;
              $display("FAIL beat%0d lane%0d: got re=%0d im=%0d cnt=%0d expected re=%0d im=%0d cnt=%0d",
                       beat_no, bad, $signed(if2.dout_re[bad]), $signed(if2.dout_im[bad]),
                       if2.min_cnt_out[bad], b.re[bad], b.im[bad], b.cnt[bad]);
            end
            beat_no++;
          end
        end else begin
          held     = 1;
          held_re  = if2.dout_re;
          held_im  = if2.dout_im;
          held_cnt = if2.min_cnt_out;
        end
      end
      if (if2.in_valid && if2.in_ready) begin
        any_ovf = 0;
        for (int l = 0; l < DW; l++) begin
          nb.cnt[l] = int'(if2.min_cnt[l / 8]);
          nb.re[l]  = model_scale(int'($signed(if2.din_re[l])), nb.cnt[l], rnd_en, sat_en, o);
          any_ovf   = any_ovf | o;
          nb.im[l]  = model_scale(int'($signed(if2.din_im[l])), nb.cnt[l], rnd_en, sat_en, o);
          any_ovf   = any_ovf | o;
        end
        exp_q.push_back(nb);
        if (any_ovf && exp_sat < 65535) exp_sat++;
        acc_cnt++;
      end
    end
  end

  task automatic set_beat2(input int xr, input int xi, input int spread, input int c0, input int c1);
    for (int l = 0; l < DW; l++) begin
      if2.din_re[l] = IW'(xr + l * spread);
      if2.din_im[l] = IW'(xi - l * spread);
    end
    if2.min_cnt[0] = CW'(c0);
    if2.min_cnt[1] = CW'(c1);
  endtask

  task automatic send2();
    int n;
    n = 0;
    if2.in_valid = 1'b1;
    @(negedge clk);
    while (!if2.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 if2.in_valid = 1'b0;
  endtask

  task automatic wait_out2(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!if2.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk(name, 0, 1);
  endtask

  task automatic drain_check(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_satcnt"}, int'(sat_cnt2), exp_sat);
  endtask

  initial begin
    bit o;
    int base;
    int n;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    set_beat2(0, 0, 0, 13, 13);
    if4.din_re = '0; if4.din_im = '0; if4.min_cnt = '0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_in_ready", int'(if2.in_ready), 1);
    chk("rst_out_valid", int'(if2.out_valid), 0);
    chk("rst_dout", (if2.dout_re == '0 && if2.dout_im == '0 && if2.min_cnt_out == '0) ? 1 : 0, 1);
    chk("rst_sat_cnt", int'(sat_cnt2), 0);
    chk("rst_sat_cnt4", int'(sat_cnt4), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: unity exponent, two-cycle latency
    set_beat2(100, 100, 0, 13, 13);
    send2();
    @(negedge clk);
    chk("lat_1cyc_valid", int'(if2.out_valid), 0);
    @(negedge clk);
    chk("lat_2cyc_valid", int'(if2.out_valid), 1);
    chk("t1_lane0", int'($signed(if2.dout_re[0])), 100);
    chk("t1_lane15", int'($signed(if2.dout_im[15])), 100);
    chk("t1_cnt", int'(if2.min_cnt_out[9]), 13);
    drain_check("t1");

    // 2: per-group exponents, floor vs round
    @(posedge clk); #1;
    set_beat2(-7, 3, 0, 10, 16);
    send2();
    wait_out2("t2a_timeout");
    chk("t2a_m7_trunc", int'($signed(if2.dout_re[0])), -1);
    chk("t2a_grp1_3", int'($signed(if2.dout_im[8])), 24);
    chk("t2a_grp0_3", int'($signed(if2.dout_im[0])), 0);
    @(posedge clk); #1;
    rnd_en = 1'b1;
    set_beat2(-7, 4, 0, 10, 16);
    send2();
    rnd_en = 1'b0;
    wait_out2("t2b_timeout");
    chk("t2b_m7_round", int'($signed(if2.dout_re[0])), -1);
    chk("t2b_4_round", int'($signed(if2.dout_im[0])), 1);
    chk("t2b_grp1_m7", int'($signed(if2.dout_re[8])), -56);
    drain_check("t2");

    // 3: saturation and wrap, overflow counting
    chk("t3_sat_before", int'(sat_cnt2), 0);
    @(posedge clk); #1;
    sat_en = 1'b1;
    set_beat2(100, -100, 0, 20, 20);
    send2();
    sat_en = 1'b0;
    wait_out2("t3a_timeout");
    chk("t3_clamp_pos", int'($signed(if2.dout_re[0])), 2047);
    chk("t3_clamp_neg", int'($signed(if2.dout_im[0])), -2048);
    chk("t3_sat_cnt1", int'(sat_cnt2), 1);
    @(posedge clk); #1;
    set_beat2(100, 0, 0, 20, 20);
    send2();
    wait_out2("t3b_timeout");
    chk("t3_wrap", int'($signed(if2.dout_re[3])), 512);
    chk("t3_sat_cnt2", int'(sat_cnt2), 2);
    drain_check("t3");

    // 4: backpressure with 4 streamed beats and mixed modes
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 if2.out_ready = 1'b1;
      end
      begin
        set_beat2(-300, 77, 37, 10, 15);  rnd_en = 1'b1; send2();
        set_beat2(1000, -999, -61, 13, 0); rnd_en = 1'b0; send2();
        set_beat2(-5, 5, 3, 7, 13);       rnd_en = 1'b1; sat_en = 1'b1; send2();
        set_beat2(60, -60, 11, 18, 11);   rnd_en = 1'b0; sat_en = 1'b0; send2();
      end
      begin
        n = 0;
        while (n < 10) begin
          @(negedge clk);
          if (!if2.in_ready) break;
          n++;
        end
        chk("t4_stall_seen", (n < 10) ? 1 : 0, 1);
        chk("t4_stall_after", acc_cnt - base, 2);
      end
    join
    drain_check("t4");
    chk("t4_all_in", acc_cnt - base, 4);

    // 5: four-group build
    @(posedge clk); #1;
    for (int l = 0; l < DW; l++) begin
      if4.din_re[l] = IW'(8);
      if4.din_im[l] = IW'(-8);
    end
    if4.min_cnt[0] = CW'(13); if4.min_cnt[1] = CW'(12);
    if4.min_cnt[2] = CW'(14); if4.min_cnt[3] = CW'(0);
    if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t5_valid", int'(if4.out_valid), 1);
    chk("t5_g0", int'($signed(if4.dout_re[2])), 8);
    chk("t5_g1", int'($signed(if4.dout_re[5])), 4);
    chk("t5_g2", int'($signed(if4.dout_re[11])), 16);
    chk("t5_g3", int'($signed(if4.dout_re[12])), 0);
    chk("t5_g3_neg", int'($signed(if4.dout_im[15])), -1);
    chk("t5_cnt_g2", int'(if4.min_cnt_out[8]), 14);
    for (int l = 0; l < DW; l++)
      chk("t5_model", int'($signed(if4.dout_im[l])), model_scale(-8, int'(if4.min_cnt[l / 4]), 1'b0, 1'b0, o));

    // 6: reset with beats in flight, then clr_sat priority
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
    set_beat2(100, 0, 0, 20, 20);
    send2();
    set_beat2(5, 5, 0, 13, 13);
    send2();
    chk("t6_inflight", int'(if2.out_valid), 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", int'(if2.out_valid), 0);
    chk("t6_rst_ready", int'(if2.in_ready), 1);
    chk("t6_rst_sat", int'(sat_cnt2), 0);
    exp_q.delete();
    exp_sat = 0;
    @(negedge clk);
    rstn = 1'b1;
    if2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_ghost", int'(if2.out_valid), 0);
    @(posedge clk); #1;
    clr_sat = 1'b1;
    sat_en = 1'b1;
    set_beat2(100, 0, 0, 20, 20);
    send2();
    wait_out2("t6_clr_timeout");
    @(posedge clk); #1;
    clr_sat = 1'b0;
    exp_sat = 0;
    chk("t6_clr_prio", int'(sat_cnt2), 0);
    set_beat2(-100, 0, 0, 20, 20);
    send2();
    sat_en = 1'b0;
    drain_check("t6");
    chk("t6_sat_after_clr", int'(sat_cnt2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
